// File: rtl/tsu_ns_gen_if.sv
// -----------------------------------------------------------------------------
// tsu_ns_gen_if
// Single-item MVB-style timestamp stream carrying the integer-ns time from
// tsu_ns_gen to the TSU input of the network module.
//
// Signals:
//   TS_NS       timestamp, integer ns (TS_WIDTH bits)
//   TS_VLD      item valid (MVB VLD[0])
//   TS_SRC_RDY  stream valid
//   TS_DST_RDY  consumer ready
//
// Modports:
//   master  timestamp producer (drives TS_NS/TS_VLD/TS_SRC_RDY)
//   slave   timestamp consumer (drives TS_DST_RDY)
// -----------------------------------------------------------------------------
interface tsu_ns_gen_if #(
  parameter int TS_WIDTH = 64
);

  logic [TS_WIDTH-1:0] TS_NS;
  logic                TS_VLD;
  logic                TS_SRC_RDY;
  logic                TS_DST_RDY;

  modport master (
    output TS_NS,
    output TS_VLD,
    output TS_SRC_RDY,
    input  TS_DST_RDY
  );

  modport slave (
    input  TS_NS,
    input  TS_VLD,
    input  TS_SRC_RDY,
    output TS_DST_RDY
  );

endinterface

// File: rtl/tsu_ns_gen.sv
// -----------------------------------------------------------------------------
// tsu_ns_gen
// Free-running nanosecond timestamp generator for the network module's TSU.
// A fixed-point accumulator {int ns, frac ns} advances by a runtime
// configurable increment every clock. The time can be loaded absolutely or
// nudged by a one-shot signed offset. The integer part is presented as a
// single-item MVB-style stream that holds stable under backpressure and
// always resumes with the current time (stale values are dropped).
//
// Ports:
//   CLK           timestamp clock
//   RESET_N       asynchronous active-low reset
//   CFG_INC       new increment, fixed point ns/cycle (INC_INT.FRAC)
//   CFG_INC_WR    pulse: latch CFG_INC (used from the next cycle on)
//   CFG_LOAD_VAL  absolute time, integer ns
//   CFG_LOAD      pulse: load counter, clear fraction, enter RUN
//   CFG_ADJ       signed ns offset
//   CFG_ADJ_WR    pulse: apply CFG_ADJ once (ignored when CFG_LOAD is high)
//   ts            timestamp stream (tsu_ns_gen_if.master)
//   SYNCED        high in RUN state
//
// Build option:
//   TSU_NS_GEN_AUTO_START_EN  when defined, the block enters RUN on the first
//                             clock after reset release with time starting
//                             at 0; CFG_LOAD then acts as a reload.
// -----------------------------------------------------------------------------
module tsu_ns_gen #(
  parameter int TS_WIDTH      = 64,
  parameter int FRAC_WIDTH    = 32,
  parameter int INC_INT_WIDTH = 8,
  parameter logic [INC_INT_WIDTH+FRAC_WIDTH-1:0] INC_DEFAULT =
    (INC_INT_WIDTH+FRAC_WIDTH)'(5) << FRAC_WIDTH,
  parameter int ADJ_WIDTH     = 32
) (
  input  logic                              CLK,
  input  logic                              RESET_N,
  input  logic [INC_INT_WIDTH+FRAC_WIDTH-1:0] CFG_INC,
  input  logic                              CFG_INC_WR,
  input  logic [TS_WIDTH-1:0]               CFG_LOAD_VAL,
  input  logic                              CFG_LOAD,
  input  logic [ADJ_WIDTH-1:0]              CFG_ADJ,
  input  logic                              CFG_ADJ_WR,
  tsu_ns_gen_if.master                      ts,
  output logic                              SYNCED
);

  localparam int ACC_W = TS_WIDTH + FRAC_WIDTH;
  localparam int INC_W = INC_INT_WIDTH + FRAC_WIDTH;

  typedef enum logic {
    ST_UNSYNC = 1'b0,
    ST_RUN    = 1'b1
  } state_t;

  state_t              state_q, state_d;
  logic [ACC_W-1:0]    acc_q, acc_d;
  logic [INC_W-1:0]    inc_q, inc_d;
  logic [TS_WIDTH-1:0] ts_ns_q, ts_ns_d;
  logic                vld_q, vld_d;

  logic [ACC_W-1:0]    inc_ext;
  logic [ACC_W-1:0]    adj_ext;
  logic [ACC_W-1:0]    step;
  logic                upd;

  // Increment is unsigned; the adjustment is sign-extended to the full
  // accumulator and shifted onto the integer-ns boundary.
  assign inc_ext = ACC_W'(inc_q);
  assign adj_ext = ACC_W'($signed(CFG_ADJ)) << FRAC_WIDTH;

  // ---------------------------------------------------------------------------
  // FSM: UNSYNC until the first load, then RUN until reset.
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q <= ST_UNSYNC;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_UNSYNC: begin
`ifdef TSU_NS_GEN_AUTO_START_EN
        state_d = ST_RUN;
`else
        if (CFG_LOAD) begin
          state_d = ST_RUN;
        end
`endif
      end
      ST_RUN:  state_d = ST_RUN;
      default: state_d = ST_UNSYNC;
    endcase
  end

  assign SYNCED = (state_q == ST_RUN);

  // ---------------------------------------------------------------------------
  // Accumulator / increment next-state. Load beats adjust; the increment
  // register written this cycle only takes effect from the next cycle, so the
  // sum always uses inc_q.
  // ---------------------------------------------------------------------------
  always_comb begin
    step = inc_ext;
    if (CFG_ADJ_WR) begin
      step = inc_ext + adj_ext;
    end
`ifdef TSU_NS_GEN_AUTO_START_EN
    // The single UNSYNC cycle after reset holds time at 0 so that the first
    // valid item carries exactly 0.
    if (state_q == ST_UNSYNC) begin
      step = '0;
    end
`endif
    if (CFG_LOAD) begin
      acc_d = {CFG_LOAD_VAL, {FRAC_WIDTH{1'b0}}};
    end else begin
      acc_d = acc_q + step;
    end
    inc_d = CFG_INC_WR ? CFG_INC : inc_q;
  end

  // ---------------------------------------------------------------------------
  // Output register. Updates whenever nothing valid is pending or the
  // consumer is ready; it samples acc_d so the output matches the accumulator
  // value committed at the same edge (a load shows up exactly on the next
  // cycle). The counter itself never stalls.
  // ---------------------------------------------------------------------------
  assign upd = !vld_q || ts.TS_DST_RDY;

  always_comb begin
    ts_ns_d = ts_ns_q;
    vld_d   = vld_q;
    if (upd) begin
      ts_ns_d = acc_d[ACC_W-1:FRAC_WIDTH];
      vld_d   = (state_d == ST_RUN);
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      acc_q   <= '0;
      inc_q   <= INC_DEFAULT;
      ts_ns_q <= '0;
      vld_q   <= 1'b0;
    end else begin
      acc_q   <= acc_d;
      inc_q   <= inc_d;
      ts_ns_q <= ts_ns_d;
      vld_q   <= vld_d;
    end
  end

  assign ts.TS_NS      = ts_ns_q;
  assign ts.TS_VLD     = vld_q;
  assign ts.TS_SRC_RDY = vld_q;

endmodule

// File: tb/tb_tsu_ns_gen.sv
// -----------------------------------------------------------------------------
// tb_tsu_ns_gen
// Self-checking bench for tsu_ns_gen (default build). A table of per-cycle
// vectors {config inputs, consumer ready, expected timestamp/valid} is applied
// one clock at a time; reset and async-reset corner cases are hand-written.
// -----------------------------------------------------------------------------
module tb_tsu_ns_gen;

  logic        clk;
  logic        rst_n;
  logic [39:0] cfg_inc;
  logic        cfg_inc_wr;
  logic [63:0] cfg_load_val;
  logic        cfg_load;
  logic [31:0] cfg_adj;
  logic        cfg_adj_wr;
  logic        synced;

  tsu_ns_gen_if #(.TS_WIDTH(64)) ts_if ();

  tsu_ns_gen dut (
    .CLK          (clk),
    .RESET_N      (rst_n),
    .CFG_INC      (cfg_inc),
    .CFG_INC_WR   (cfg_inc_wr),
    .CFG_LOAD_VAL (cfg_load_val),
    .CFG_LOAD     (cfg_load),
    .CFG_ADJ      (cfg_adj),
    .CFG_ADJ_WR   (cfg_adj_wr),
    .ts           (ts_if),
    .SYNCED       (synced)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        load;
    logic [63:0] load_val;
    logic        adj_wr;
    logic [31:0] adj;
    logic        inc_wr;
    logic [39:0] inc;
    logic        dst_rdy;
    logic [63:0] exp_ts;
    logic        exp_vld;
  } vec_t;

  vec_t tbl[$];
  int   n_vec  = 0;
  int   n_miss = 0;

  localparam logic [39:0] INC_5   = 40'h05_0000_0000;
  localparam logic [39:0] INC_6P4 = 40'h06_6666_6666;
  localparam logic [39:0] INC_0   = 40'h00_0000_0000;
  localparam logic [63:0] TOP_M10 = 64'hFFFF_FFFF_FFFF_FFF6;
  localparam logic [63:0] TOP_M5  = 64'hFFFF_FFFF_FFFF_FFFB;

  task automatic check(input string name, input int idx,
                       input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s [%0d]: got %0d (0x%0h), expected %0d (0x%0h)",
               name, idx, act, act, exp, exp);
    end
  endtask

  task automatic add(input logic ld, input logic [63:0] lv,
                     input logic aw, input logic [31:0] a,
                     input logic iw, input logic [39:0] inc,
                     input logic dr, input logic [63:0] ets, input logic ev);
    vec_t v;
    v.load = ld; v.load_val = lv; v.adj_wr = aw; v.adj = a;
    v.inc_wr = iw; v.inc = inc; v.dst_rdy = dr; v.exp_ts = ets; v.exp_vld = ev;
    tbl.push_back(v);
  endtask

  // Plain increment cycle with consumer ready.
  task automatic idle(input logic [63:0] ets);
    add(0, 0, 0, 0, 0, 0, 1, ets, 1);
  endtask

  task automatic drive_idle();
    cfg_inc = '0; cfg_inc_wr = 0; cfg_load_val = '0; cfg_load = 0;
    cfg_adj = '0; cfg_adj_wr = 0; ts_if.TS_DST_RDY = 1;
  endtask

  task automatic check_outputs(input string tag, input int idx,
                               input logic [63:0] ets, input logic ev,
                               input logic esync);
    check({tag, " TS_NS"},      idx, ts_if.TS_NS, ets);
    check({tag, " TS_VLD"},     idx, 64'(ts_if.TS_VLD), 64'(ev));
    check({tag, " TS_SRC_RDY"}, idx, 64'(ts_if.TS_SRC_RDY), 64'(ev));
    check({tag, " SYNCED"},     idx, 64'(synced), 64'(esync));
  endtask

  initial begin
    // ---------------- stimulus table (one entry per clock) ----------------
    add(1, 64'd1000, 0, 0, 0, 0, 1, 64'd1000, 1);     // first load -> RUN
    idle(1005); idle(1010); idle(1015);
    add(0, 0, 0, 0, 1, INC_6P4, 1, 64'd1020, 1);      // old inc still used
    idle(1026); idle(1032); idle(1039); idle(1045); idle(1051); idle(1058);
    add(0, 0, 0, 0, 1, INC_5, 1, 64'd1064, 1);        // 6.4 used once more
    idle(1069);
    add(1, 64'd1995, 0, 0, 0, 0, 1, 64'd1995, 1);     // reload in RUN
    idle(2000);
    add(0, 0, 1, -32'sd20, 0, 0, 1, 64'd1985, 1);     // 2000 + 5 - 20
    idle(1990);
    add(1, 64'd3000, 1, -32'sd50, 0, 0, 1, 64'd3000, 1); // load beats adjust
    idle(3005);
    for (int k = 0; k < 10; k++) add(0, 0, 0, 0, 0, 0, 0, 64'd3005, 1);
    add(0, 0, 0, 0, 0, 0, 1, 64'd3060, 1);            // +55: stale dropped
    idle(3065);
    add(1, TOP_M10, 0, 0, 0, 0, 1, TOP_M10, 1);       // wrap sequence
    idle(TOP_M5); idle(0); idle(5);
    add(0, 0, 1, -32'sd20, 0, 0, 1, TOP_M10, 1);      // negative wraps
    idle(TOP_M5);
    add(0, 0, 0, 0, 1, INC_0, 1, 64'd0, 1);           // freeze from next cycle
    idle(0); idle(0);
    add(0, 0, 0, 0, 1, INC_5, 1, 64'd0, 1);           // 0 used once more
    idle(5);

    // ---------------- reset state ----------------
    drive_idle();
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #1 check_outputs("reset", 0, 64'd0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;

    // ---------------- 100 idle cycles while UNSYNC ----------------
    repeat (100) @(posedge clk);
    #1 check_outputs("unsync", 100, 64'd500, 1'b0, 1'b0);

    // ---------------- table ----------------
    foreach (tbl[i]) begin
      @(negedge clk);
      cfg_load          = tbl[i].load;
      cfg_load_val      = tbl[i].load_val;
      cfg_adj_wr        = tbl[i].adj_wr;
      cfg_adj           = tbl[i].adj;
      cfg_inc_wr        = tbl[i].inc_wr;
      cfg_inc           = tbl[i].inc;
      ts_if.TS_DST_RDY  = tbl[i].dst_rdy;
      @(posedge clk);
      #1 check_outputs("vec", i, tbl[i].exp_ts, tbl[i].exp_vld, 1'b1);
    end
    @(negedge clk) drive_idle();

    // ---------------- asynchronous reset between edges ----------------
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1 check_outputs("async_rst", 0, 64'd0, 1'b0, 1'b0);
    @(posedge clk);
    #1 check_outputs("rst_held", 0, 64'd0, 1'b0, 1'b0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1 check_outputs("post_rst", 1, 64'd5, 1'b0, 1'b0);

    // Load while consumer not ready: nothing valid pending, so it updates.
    @(negedge clk);
    cfg_load = 1; cfg_load_val = 64'd77; ts_if.TS_DST_RDY = 0;
    @(posedge clk);
    #1 check_outputs("load_nrdy", 0, 64'd77, 1'b1, 1'b1);
    @(negedge clk) cfg_load = 0;
    @(posedge clk);
    #1 check_outputs("load_nrdy", 1, 64'd77, 1'b1, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
